// File: rtl/hex_onehot_decoder.sv
// hex_onehot_decoder
// Registered 4-to-16 decoder fed by a valid/ready handshake.
// An accepted hex code is shown as a one-hot line for HOLD_CYCLES cycles.
// With sweep high, the block keeps stepping the code 0..F, wrapping at F,
// until sweep is seen low at the end of a hold.

module hex_onehot_decoder #(
  parameter int HOLD_CYCLES = 4,
  parameter int CNT_W       = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_code,
  input  logic        sweep,
  output logic [15:0] out,
  output logic        out_valid,
  output logic [3:0]  out_code,
  output logic        done
);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  // The counter counts the cycles still to go after the current one, so a
  // reload value of HOLD_CYCLES-1 gives exactly HOLD_CYCLES visible cycles.
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(HOLD_CYCLES - 1);

  state_t            state;
  state_t            state_next;
  logic [CNT_W-1:0]  counter;
  logic [CNT_W-1:0]  counter_next;
  logic [3:0]        code_next;
  logic [3:0]        code_inc;
  logic [15:0]       out_next;
  logic              out_valid_next;
  logic              done_next;

  function automatic logic [15:0] onehot(input logic [3:0] code);
    onehot = 16'h0001 << code;
  endfunction

  // A new code can be taken only while nothing is being driven.
  assign in_ready = (state == IDLE);

  // The next sweep step wraps naturally in 4 bits (F -> 0).
  assign code_inc = out_code + 4'd1;

  // All state and outputs are registered; reset clears them at once, even mid-hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      counter   <= '0;
      out_code  <= 4'h0;
      out       <= 16'h0000;
      out_valid <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_next;
      counter   <= counter_next;
      out_code  <= code_next;
      out       <= out_next;
      out_valid <= out_valid_next;
      done      <= done_next;
    end
  end

  // Next-state logic: accept in IDLE, count down in HOLD, then either step
  // to the next code (sweep) or drop the line and pulse done.
  always_comb begin
    state_next     = state;
    counter_next   = counter;
    code_next      = out_code;
    out_next       = out;
    out_valid_next = out_valid;
    done_next      = 1'b0;

    case (state)
      IDLE: begin
        if (in_valid) begin
          code_next      = in_code;
          out_next       = onehot(in_code);
          out_valid_next = 1'b1;
          counter_next   = RELOAD;
          state_next     = HOLD;
        end
      end

      HOLD: begin
        if (counter != '0) begin
          counter_next = counter - 1'b1;
        end else if (sweep) begin
          code_next    = code_inc;
          out_next     = onehot(code_inc);
          counter_next = RELOAD;
        end else begin
          out_next       = 16'h0000;
          out_valid_next = 1'b0;
          done_next      = 1'b1;
          state_next     = IDLE;
        end
      end

      default: begin
        state_next     = IDLE;
        out_next       = 16'h0000;
        out_valid_next = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_hex_onehot_decoder.sv
// tb_hex_onehot_decoder
// Drives two decoders (HOLD_CYCLES=4 and HOLD_CYCLES=1) with directed and
// random stimulus and compares them every cycle against a cycle-age model.

module tb_hex_onehot_decoder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        in_valid [2];
  logic [3:0]  in_code  [2];
  logic        sweep    [2];
  logic        in_ready [2];
  logic [15:0] out_w    [2];
  logic        out_valid[2];
  logic [3:0]  out_code [2];
  logic        done     [2];

  int checkCount = 0;
  int passCount  = 0;

  // reference model: whether a line is lit, which code, and how many cycles
  // that code has been visible so far
  bit m_active[2];
  int m_code  [2];
  int m_age   [2];
  bit m_done  [2];
  int holdOf  [2] = '{4, 1};

  hex_onehot_decoder #(.HOLD_CYCLES(4), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_code(in_code[0]),
    .sweep(sweep[0]), .out(out_w[0]), .out_valid(out_valid[0]),
    .out_code(out_code[0]), .done(done[0])
  );

  hex_onehot_decoder #(.HOLD_CYCLES(1), .CNT_W(8)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_code(in_code[1]),
    .sweep(sweep[1]), .out(out_w[1]), .out_valid(out_valid[1]),
    .out_code(out_code[1]), .done(done[1])
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
  endtask

  task automatic applyStimulus(input int i, input bit v, input logic [3:0] c,
                               input bit s);
    in_valid[i] = v;
    in_code[i]  = c;
    sweep[i]    = s;
  endtask

  task automatic modelReset();
    for (int i = 0; i < 2; i++) begin
      m_active[i] = 0; m_code[i] = 0; m_age[i] = 0; m_done[i] = 0;
    end
  endtask

  task automatic modelEdge(input int i);
    m_done[i] = 0;
    if (!m_active[i]) begin
      if (in_valid[i]) begin
        m_active[i] = 1;
        m_code[i]   = int'(in_code[i]);
        m_age[i]    = 1;
      end
    end else if (m_age[i] == holdOf[i]) begin
      if (sweep[i]) begin
        m_code[i] = (m_code[i] + 1) % 16;
        m_age[i]  = 1;
      end else begin
        m_active[i] = 0;
        m_done[i]   = 1;
      end
    end else begin
      m_age[i]++;
    end
  endtask

  task automatic compareAll();
    for (int i = 0; i < 2; i++) begin
      checkOutput($sformatf("out[%0d]", i), 32'(out_w[i]),
                  m_active[i] ? (32'd1 << m_code[i]) : 32'd0);
      checkOutput($sformatf("out_valid[%0d]", i), 32'(out_valid[i]), 32'(m_active[i]));
      checkOutput($sformatf("in_ready[%0d]", i), 32'(in_ready[i]), 32'(!m_active[i]));
      checkOutput($sformatf("out_code[%0d]", i), 32'(out_code[i]), 32'(m_code[i]));
      checkOutput($sformatf("done[%0d]", i), 32'(done[i]), 32'(m_done[i]));
      checkOutput($sformatf("onehot0[%0d]", i), 32'($onehot0(out_w[i])), 32'd1);
    end
  endtask

  // one clock: model follows the edge, outputs compared on the falling edge
  task automatic tick();
    @(posedge clk);
    for (int i = 0; i < 2; i++) modelEdge(i);
    @(negedge clk);
    compareAll();
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  initial begin
    int busy;
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) applyStimulus(i, 0, 4'h0, 0);
    modelReset();

    // reset state
    @(negedge clk);
    checkOutput("rst_out", 32'(out_w[0]), 32'h0);
    checkOutput("rst_out_valid", 32'(out_valid[0]), 32'h0);
    checkOutput("rst_in_ready", 32'(in_ready[0]), 32'h1);
    checkOutput("rst_done", 32'(done[0]), 32'h0);
    checkOutput("rst_out_code", 32'(out_code[0]), 32'h0);
    rst_n = 1'b1;
    ticks(2);

    // single decode of every code
    for (int k = 0; k < 16; k++) begin
      applyStimulus(0, 1, 4'(k), 0);
      tick();
      applyStimulus(0, 0, 4'(k), 0);
      if (k == 0)  checkOutput("dec_0", 32'(out_w[0]), 32'h0001);
      if (k == 10) checkOutput("dec_A", 32'(out_w[0]), 32'h0400);
      if (k == 15) checkOutput("dec_F", 32'(out_w[0]), 32'h8000);
      ticks(3);
      checkOutput("dec_hold_last", 32'(out_w[0]), 32'd1 << k);
      tick();
      checkOutput("dec_done", 32'(done[0]), 32'h1);
      checkOutput("dec_idle_out", 32'(out_w[0]), 32'h0);
    end
    tick();

    // backpressure
    applyStimulus(0, 1, 4'h3, 0);
    tick();
    applyStimulus(0, 1, 4'h5, 0);
    busy = 0;
    while (!in_ready[0] && busy < 20) begin
      busy++;
      tick();
    end
    checkOutput("bp_busy_cycles", 32'(busy), 32'd4);
    tick();
    applyStimulus(0, 0, 4'h5, 0);
    checkOutput("bp_code5", 32'(out_w[0]), 32'h0020);
    ticks(5);

    // sweep across the wrap, then stop during code 1
    applyStimulus(0, 1, 4'hE, 1);
    tick();
    applyStimulus(0, 0, 4'h0, 1);
    checkOutput("sw_E", 32'(out_w[0]), 32'h4000);
    ticks(4);
    checkOutput("sw_F", 32'(out_w[0]), 32'h8000);
    ticks(4);
    checkOutput("sw_0", 32'(out_w[0]), 32'h0001);
    ticks(4);
    checkOutput("sw_1", 32'(out_w[0]), 32'h0002);
    tick();
    applyStimulus(0, 0, 4'h0, 0);
    ticks(2);
    checkOutput("sw_1_last", 32'(out_w[0]), 32'h0002);
    tick();
    checkOutput("sw_done", 32'(done[0]), 32'h1);
    checkOutput("sw_out_code", 32'(out_code[0]), 32'h1);
    checkOutput("sw_idle", 32'(out_w[0]), 32'h0);
    tick();

    // asynchronous reset in the middle of a hold
    applyStimulus(0, 1, 4'h7, 0);
    tick();
    applyStimulus(0, 0, 4'h7, 0);
    tick();
    checkOutput("ar_before", 32'(out_w[0]), 32'h0080);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("ar_out", 32'(out_w[0]), 32'h0);
    checkOutput("ar_out_valid", 32'(out_valid[0]), 32'h0);
    checkOutput("ar_in_ready", 32'(in_ready[0]), 32'h1);
    modelReset();
    @(negedge clk);
    rst_n = 1'b1;
    compareAll();
    applyStimulus(0, 1, 4'h9, 0);
    tick();
    applyStimulus(0, 0, 4'h9, 0);
    checkOutput("ar_reaccept", 32'(out_w[0]), 32'h0200);
    ticks(5);

    // single-cycle hold with sweep from code 0
    applyStimulus(1, 1, 4'h0, 1);
    tick();
    applyStimulus(1, 0, 4'h0, 1);
    checkOutput("h1_step0", 32'(out_w[1]), 32'h0001);
    for (int s = 1; s <= 16; s++) begin
      tick();
      checkOutput($sformatf("h1_step%0d", s), 32'(out_w[1]), 32'd1 << (s % 16));
    end
    applyStimulus(1, 0, 4'h0, 0);
    tick();
    checkOutput("h1_done", 32'(done[1]), 32'h1);
    ticks(2);

    // random traffic on both decoders
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < 2; i++)
        applyStimulus(i, ($urandom % 3) == 0, 4'($urandom), ($urandom % 4) == 0);
      tick();
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
